// File: rtl/vga_sprite_mixer_pkg.sv
// Shared constants and payload types for the VGA sprite compositor.
//   H_ACTIVE/V_ACTIVE : visible raster size, used to size the background
//   PIX_W             : 4:4:4 pixel width
//   TRANS_KEY_DEF     : default transparent colour key for sprite data
//   sync_t            : per-pixel control carried alongside the pixel pipeline
package vga_sprite_mixer_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned PIX_W    = 12;

  localparam logic [PIX_W-1:0] TRANS_KEY_DEF = 12'h000;

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam int unsigned SYNC_W = $bits(sync_t);

endpackage

// File: rtl/vga_sprite_hit.sv
// One sprite channel: frame-latched shadow position/size, hit test against
// the current pixel and the registered sprite-ROM address.
//   clk_25m, rst_n      : pixel clock, async active-low reset
//   frame_start_i       : loads the shadow registers from the live inputs
//   en_i, x_i, y_i      : live sprite enable and top-left corner
//   w_i, h_i            : live sprite size
//   hc_i, vc_i          : current pixel coordinate
//   hit_o               : registered hit flag (stage 1)
//   addr_o              : registered ROM address, 0 when not hit (stage 1)
module vga_sprite_hit #(
  parameter int unsigned CW = 10,
  parameter int unsigned AW = 17
) (
  input  logic          clk_25m,
  input  logic          rst_n,
  input  logic          frame_start_i,
  input  logic          en_i,
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  logic [CW-1:0] w_i,
  input  logic [CW-1:0] h_i,
  input  logic [CW-1:0] hc_i,
  input  logic [CW-1:0] vc_i,
  output logic          hit_o,
  output logic [AW-1:0] addr_o
);

  logic          en_q;
  logic [CW-1:0] x_q, y_q, w_q, h_q;

  logic [CW:0]   x_end_c, y_end_c;
  logic [CW-1:0] dx_c, dy_c;
  logic          in_x_c, in_y_c, hit_c;
  logic [AW-1:0] addr_c;

  logic          hit_q;
  logic [AW-1:0] addr_q;

  // Shadow copy of the sprite geometry, refreshed only on frame_start
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      w_q  <= '0;
      h_q  <= '0;
    end else if (frame_start_i) begin
      en_q <= en_i;
      x_q  <= x_i;
      y_q  <= y_i;
      w_q  <= w_i;
      h_q  <= h_i;
    end
  end

  // Bounds carry one extra bit so a sprite hanging off the edge clips instead of wrapping
  always_comb begin
    x_end_c = {1'b0, x_q} + {1'b0, w_q};
    y_end_c = {1'b0, y_q} + {1'b0, h_q};
    in_x_c  = (hc_i >= x_q) && ({1'b0, hc_i} < x_end_c);
    in_y_c  = (vc_i >= y_q) && ({1'b0, vc_i} < y_end_c);
    hit_c   = en_q && in_x_c && in_y_c;
    dx_c    = hc_i - x_q;
    dy_c    = vc_i - y_q;
    addr_c  = '0;
    if (hit_c) begin
      addr_c = AW'(dx_c) + AW'(w_q) * AW'(dy_c);
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_c;
      addr_q <= addr_c;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/vga_sprite_mixer.sv
// Pixel compositor: NUM_SPR prioritised sprite layers over a downscaled
// background, with ROM address generation and sync re-alignment.
//   clk_25m, rst_n            : pixel clock, async active-low reset
//   hc, vc, valid             : pixel coordinate and active-video flag
//   hsync_in, vsync_in        : syncs aligned with hc/vc
//   frame_start               : latches spr_* into the per-sprite shadow regs
//   spr_en/x/y/w/h            : packed per-sprite geometry, sprite i at [i*CW+:CW]
//   spr_addr, spr_data        : sprite-ROM address out / data back ROM_LAT later
//   bg_addr, bg_data          : background-ROM address out / data back
//   vgaRed/Green/Blue         : registered composited colour
//   hsync_out, vsync_out      : syncs delayed by ROM_LAT+2 to match RGB
module vga_sprite_mixer
  import vga_sprite_mixer_pkg::*;
#(
  parameter int unsigned   NUM_SPR   = 4,
  parameter int unsigned   CW        = 10,
  parameter int unsigned   AW        = 17,
  parameter int unsigned   PW        = PIX_W,
  parameter int unsigned   ROM_LAT   = 1,
  parameter int unsigned   BG_SHIFT  = 1,
  parameter int unsigned   BG_W      = H_ACTIVE >> BG_SHIFT,
  parameter int unsigned   BG_DEPTH  = (H_ACTIVE >> BG_SHIFT) * (V_ACTIVE >> BG_SHIFT),
  parameter logic [PW-1:0] TRANS_KEY = PW'(TRANS_KEY_DEF)
) (
  input  logic                  clk_25m,
  input  logic                  rst_n,
  input  logic [CW-1:0]         hc,
  input  logic [CW-1:0]         vc,
  input  logic                  valid,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  frame_start,
  input  logic [NUM_SPR-1:0]    spr_en,
  input  logic [NUM_SPR*CW-1:0] spr_x,
  input  logic [NUM_SPR*CW-1:0] spr_y,
  input  logic [NUM_SPR*CW-1:0] spr_w,
  input  logic [NUM_SPR*CW-1:0] spr_h,
  output logic [NUM_SPR*AW-1:0] spr_addr,
  input  logic [NUM_SPR*PW-1:0] spr_data,
  output logic [AW-1:0]         bg_addr,
  input  logic [PW-1:0]         bg_data,
  output logic [3:0]            vgaRed,
  output logic [3:0]            vgaGreen,
  output logic [3:0]            vgaBlue,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  localparam int unsigned SW = AW + 1;            // background sum width, room for one overflow step
  localparam int unsigned DW = NUM_SPR + SYNC_W;  // delay-line payload width

  // ---------------- stage 1: sprite channels ----------------
  logic [NUM_SPR-1:0] hit_s1;

  for (genvar g = 0; g < int'(NUM_SPR); g++) begin : g_spr
    vga_sprite_hit #(
      .CW (CW),
      .AW (AW)
    ) u_hit (
      .clk_25m       (clk_25m),
      .rst_n         (rst_n),
      .frame_start_i (frame_start),
      .en_i          (spr_en[g]),
      .x_i           (spr_x[g*CW +: CW]),
      .y_i           (spr_y[g*CW +: CW]),
      .w_i           (spr_w[g*CW +: CW]),
      .h_i           (spr_h[g*CW +: CW]),
      .hc_i          (hc),
      .vc_i          (vc),
      .hit_o         (hit_s1[g]),
      .addr_o        (spr_addr[g*AW +: AW])
    );
  end

  // ---------------- stage 1: background address ----------------
  logic [CW-1:0] bg_x_c, bg_y_c;
  logic [SW-1:0] bg_sum_c;
  logic [AW-1:0] bg_addr_c;
  logic [AW-1:0] bg_addr_q;
  sync_t         sync_s1_q;

  // Row-major address into the downscaled image; a single conditional subtract wraps at BG_DEPTH
  always_comb begin
    bg_x_c    = hc >> BG_SHIFT;
    bg_y_c    = vc >> BG_SHIFT;
    bg_sum_c  = SW'(bg_x_c) + SW'(BG_W) * SW'(bg_y_c);
    bg_addr_c = AW'(bg_sum_c);
    if (bg_sum_c >= SW'(BG_DEPTH)) begin
      bg_addr_c = AW'(bg_sum_c - SW'(BG_DEPTH));
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      bg_addr_q <= '0;
      sync_s1_q <= '0;
    end else begin
      bg_addr_q <= bg_addr_c;
      sync_s1_q <= '{valid: valid, hsync: hsync_in, vsync: vsync_in};
    end
  end

  assign bg_addr = bg_addr_q;

  // ---------------- delay line: align hits and syncs with ROM data ----------------
  logic [DW-1:0] dly_q [ROM_LAT];
  logic [DW-1:0] dly_tail;
  logic [NUM_SPR-1:0] hit_d;
  sync_t         sync_d;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= {hit_s1, sync_s1_q};
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign dly_tail = dly_q[ROM_LAT-1];
  assign hit_d    = dly_tail[DW-1:SYNC_W];
  assign sync_d   = sync_t'(dly_tail[SYNC_W-1:0]);

  // ---------------- stage 2: priority / transparency select ----------------
  logic [PW-1:0] pix_c;
  logic          found_c;
  logic [PW-1:0] rgb_q;
  logic          hsync_q, vsync_q;

  // Lowest index with an opaque texel wins; blanking overrides everything
  always_comb begin
    pix_c   = bg_data;
    found_c = 1'b0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      if (!found_c && hit_d[i] && (spr_data[i*PW +: PW] != TRANS_KEY)) begin
        pix_c   = spr_data[i*PW +: PW];
        found_c = 1'b1;
      end
    end
    if (!sync_d.valid) begin
      pix_c = '0;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      rgb_q   <= pix_c;
      hsync_q <= sync_d.hsync;
      vsync_q <= sync_d.vsync;
    end
  end

  assign vgaRed    = rgb_q[PW-1 -: 4];
  assign vgaGreen  = rgb_q[PW-5 -: 4];
  assign vgaBlue   = rgb_q[PW-9 -: 4];
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Directed self-checking bench for vga_sprite_mixer.
// u_dut1: default parameters (ROM_LAT=1).
// u_dut3: ROM_LAT=3 and BG_DEPTH=76799 so the last background pixel wraps to 0.
module tb_vga_sprite_mixer;

  localparam int NUM_SPR = 4;
  localparam int CW      = 10;
  localparam int AW      = 17;
  localparam int PW      = 12;

  logic                  clk_25m;
  logic                  rst_n;
  logic [CW-1:0]         hc, vc;
  logic                  valid, hsync_in, vsync_in, frame_start;
  logic [NUM_SPR-1:0]    spr_en;
  logic [NUM_SPR*CW-1:0] spr_x, spr_y, spr_w, spr_h;
  logic [NUM_SPR*PW-1:0] spr_data;
  logic [PW-1:0]         bg_data;

  logic [NUM_SPR*AW-1:0] spr_addr1, spr_addr3;
  logic [AW-1:0]         bg_addr1, bg_addr3;
  logic [3:0]            red1, green1, blue1, red3, green3, blue3;
  logic                  hsync_out1, vsync_out1, hsync_out3, vsync_out3;

  int n_cmp = 0;
  int n_err = 0;

  vga_sprite_mixer u_dut1 (
    .clk_25m (clk_25m), .rst_n (rst_n), .hc (hc), .vc (vc), .valid (valid),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .frame_start (frame_start),
    .spr_en (spr_en), .spr_x (spr_x), .spr_y (spr_y), .spr_w (spr_w), .spr_h (spr_h),
    .spr_addr (spr_addr1), .spr_data (spr_data), .bg_addr (bg_addr1), .bg_data (bg_data),
    .vgaRed (red1), .vgaGreen (green1), .vgaBlue (blue1),
    .hsync_out (hsync_out1), .vsync_out (vsync_out1)
  );

  vga_sprite_mixer #(
    .ROM_LAT  (3),
    .BG_DEPTH (76799)
  ) u_dut3 (
    .clk_25m (clk_25m), .rst_n (rst_n), .hc (hc), .vc (vc), .valid (valid),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .frame_start (frame_start),
    .spr_en (spr_en), .spr_x (spr_x), .spr_y (spr_y), .spr_w (spr_w), .spr_h (spr_h),
    .spr_addr (spr_addr3), .spr_data (spr_data), .bg_addr (bg_addr3), .bg_data (bg_data),
    .vgaRed (red3), .vgaGreen (green3), .vgaBlue (blue3),
    .hsync_out (hsync_out3), .vsync_out (vsync_out3)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time bound");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb1();
    return 32'({red1, green1, blue1});
  endfunction

  function automatic logic [31:0] rgb3();
    return 32'({red3, green3, blue3});
  endfunction

  function automatic logic [31:0] sa1(input int i);
    return 32'(spr_addr1[i*AW +: AW]);
  endfunction

  task automatic tick();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_spr(input int i, input logic en, input int x, input int y,
                         input int w, input int h);
    spr_en[i]          = en;
    spr_x[i*CW +: CW]  = CW'(x);
    spr_y[i*CW +: CW]  = CW'(y);
    spr_w[i*CW +: CW]  = CW'(w);
    spr_h[i*CW +: CW]  = CW'(h);
  endtask

  task automatic set_pix(input int x, input int y);
    hc = CW'(x);
    vc = CW'(y);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [31:0] hpat;
  logic [31:0] vpat;

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    valid       = 1'b1;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    spr_en      = '0;
    spr_x       = '0;
    spr_y       = '0;
    spr_w       = '0;
    spr_h       = '0;
    spr_data    = '0;
    bg_data     = 12'h123;
    set_pix(300, 10);
    spr_data[0*PW +: PW] = 12'hABC;

    // Reset holds everything at zero
    ticks(3);
    chk("rst_rgb", rgb1(), 32'h0);
    chk("rst_hsync", 32'(hsync_out1), 32'h0);
    chk("rst_vsync", 32'(vsync_out1), 32'h0);
    chk("rst_bg_addr", 32'(bg_addr1), 32'h0);
    chk("rst_spr_addr", 32'(spr_addr1), 32'h0);
    chk("rst_rgb_l3", rgb3(), 32'h0);

    // Sprite configured but not latched: must stay disabled
    rst_n = 1'b1;
    set_spr(0, 1'b1, 100, 50, 30, 50);
    set_pix(110, 60);
    ticks(4);
    chk("pre_fs_rgb", rgb1(), 32'h123);
    chk("pre_fs_addr0", sa1(0), 32'h0);

    // Latch and probe bottom-right corner of sprite 0
    frame_pulse();
    set_pix(129, 99);
    tick();
    chk("s0_addr", sa1(0), 32'd1499);
    chk("bg_addr_129_99", 32'(bg_addr1), 32'd15744);
    tick();
    chk("s0_rgb_early", rgb1(), 32'h123);
    tick();
    chk("s0_rgb_lat", rgb1(), 32'hABC);

    // One pixel right of the sprite is background
    set_pix(130, 99);
    tick();
    chk("s0_miss_addr", sa1(0), 32'h0);
    ticks(2);
    chk("s0_miss_rgb", rgb1(), 32'h123);

    // Overlap of sprites 0 and 1 at (200,200)
    set_spr(0, 1'b1, 195, 195, 20, 20);
    set_spr(1, 1'b1, 190, 190, 20, 20);
    spr_data[0*PW +: PW] = 12'hF00;
    spr_data[1*PW +: PW] = 12'h0F0;
    frame_pulse();
    set_pix(200, 200);
    tick();
    chk("ovl_addr0", sa1(0), 32'd105);
    chk("ovl_addr1", sa1(1), 32'd210);
    ticks(2);
    chk("ovl_both_opaque", rgb1(), 32'hF00);
    spr_data[0*PW +: PW] = 12'h000;
    ticks(2);
    chk("ovl_s0_transp", rgb1(), 32'h0F0);
    spr_data[1*PW +: PW] = 12'h000;
    ticks(2);
    chk("ovl_both_transp", rgb1(), 32'h123);

    // Mid-frame move ignored until frame_start
    spr_data[0*PW +: PW] = 12'hF00;
    set_spr(0, 1'b1, 300, 195, 20, 20);
    ticks(3);
    chk("mid_old_rgb", rgb1(), 32'hF00);
    chk("mid_old_addr", sa1(0), 32'd105);
    frame_pulse();
    chk("mid_fs_cycle_addr", sa1(0), 32'd105);
    tick();
    chk("mid_new_addr", sa1(0), 32'h0);
    tick();
    chk("mid_old_tail_rgb", rgb1(), 32'hF00);
    tick();
    chk("mid_new_rgb", rgb1(), 32'h123);

    // Right-edge clipping and coordinate-sum overflow
    set_spr(2, 1'b1, 630, 0, 30, 480);
    set_spr(3, 1'b1, 1000, 0, 30, 10);
    spr_data[2*PW +: PW] = 12'h00F;
    spr_data[3*PW +: PW] = 12'h777;
    frame_pulse();
    set_pix(635, 10);
    tick();
    chk("edge_addr2", sa1(2), 32'd305);
    ticks(2);
    chk("edge_rgb", rgb1(), 32'h00F);
    set_pix(10, 10);
    ticks(3);
    chk("edge_no_wrap_rgb", rgb1(), 32'h123);
    chk("edge_no_wrap_addr2", sa1(2), 32'h0);
    set_pix(639, 479);
    tick();
    chk("corner_addr2", sa1(2), 32'd14379);
    chk("corner_bg_addr", 32'(bg_addr1), 32'd76799);
    chk("corner_bg_wrap", 32'(bg_addr3), 32'd0);
    ticks(2);
    chk("corner_rgb", rgb1(), 32'h00F);
    set_pix(1010, 5);
    tick();
    chk("sum_carry_addr3", sa1(3), 32'd160);
    ticks(2);
    chk("sum_carry_rgb", rgb1(), 32'h777);

    // Blanking forces black even over an opaque sprite
    set_pix(635, 10);
    valid = 1'b0;
    ticks(3);
    chk("blank_rgb", rgb1(), 32'h0);
    ticks(2);
    chk("blank_rgb_l3", rgb3(), 32'h0);

    // Sync delay: ROM_LAT+2 = 3 and 5
    hpat = 32'hB38D_52E1;
    vpat = 32'h4E71_9A3C;
    for (int n = 0; n < 24; n++) begin
      if (n >= 3) begin
        chk("hsync_l1", 32'(hsync_out1), 32'(hpat[n-3]));
        chk("vsync_l1", 32'(vsync_out1), 32'(vpat[n-3]));
      end
      if (n >= 5) begin
        chk("hsync_l3", 32'(hsync_out3), 32'(hpat[n-5]));
        chk("vsync_l3", 32'(vsync_out3), 32'(vpat[n-5]));
      end
      hsync_in = hpat[n];
      vsync_in = vpat[n];
      tick();
    end

    // Mid-frame reset flushes and clears the shadow regs
    valid    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    ticks(5);
    chk("pre_rst_rgb", rgb1(), 32'h00F);
    chk("pre_rst_rgb_l3", rgb3(), 32'h00F);
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb", rgb1(), 32'h0);
    chk("midrst_hsync", 32'(hsync_out1), 32'h0);
    chk("midrst_addr2", sa1(2), 32'h0);
    chk("midrst_bg_addr", 32'(bg_addr1), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    chk("rel_rgb_early", rgb1(), 32'h0);
    tick();
    chk("rel_rgb_bg", rgb1(), 32'h123);
    chk("rel_hsync", 32'(hsync_out1), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
